// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pkg: active-low segment encodings {a..g,dp} and glyph lookup        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  // Index 0 is the leftmost element, so SEG_DIGIT[n] is the glyph for n.
  localparam logic [0:9][7:0] SEG_DIGIT = {
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
    8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
  };

  function automatic logic [6:0] seg7_glyph(input logic [3:0] value);
    logic [7:0] seg;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
    else               seg = SEG_DASH;
    return seg[7:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_decode: one BCD digit + dp + blank -> active-low cathodes           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] cathode
);

  // A blanked digit still shows its decimal point.
  always_comb begin
    cathode    = blank ? SEG_BLANK : {seg7_glyph(bcd), 1'b1};
    cathode[0] = ~dp;
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_driver: time-multiplexed N-digit common-anode 7-seg driver     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS   = 8,
  parameter  int SLOT_CYCLES  = 100000,
  parameter  int GHOST_CYCLES = 64,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    blank_lz;
  } frame_t;

  logic [CNT_W-1:0]      slot_cnt_q,   slot_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q,  digit_idx_d;
  frame_t                pend_q,       pend_d;
  logic                  pend_valid_q, pend_valid_d;
  frame_t                act_q,        act_d;
  logic [NUM_DIGITS-1:0] anode_q,      anode_d;
  logic [7:0]            cathode_q,    cathode_d;

  logic                  slot_wrap;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_above;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            dec_cathode;

  assign slot_wrap = en && (slot_cnt_q == CNT_LAST);
  assign frame_end = slot_wrap && (digit_idx_q == IDX_LAST);

  // Scan position and the pending -> active hand-off at frame boundaries.
  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    digit_idx_d  = digit_idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    if (en) begin
      if (slot_wrap) begin
        slot_cnt_d  = '0;
        digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end
    if (frame_end && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d       = '{bcd: bcd, dp: dp_en, blank_lz: blank_lz};
      pend_valid_d = 1'b1;
    end
  end

  // Digit i blanks when every digit from i up to the MSD is zero; digit 0 never blanks.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above  = zero_above && (act_q.bcd[4*i +: 4] == 4'd0);
      lz_blank[i] = act_q.blank_lz && zero_above;
    end
  end

  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == i[IDX_W-1:0]) begin
        cur_bcd   = act_q.bcd[4*i +: 4];
        cur_dp    = act_q.dp[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  seg7_decode u_decode (
    .bcd     (cur_bcd),
    .dp      (cur_dp),
    .blank   (cur_blank),
    .cathode (dec_cathode)
  );

  always_comb begin
    anode_d   = '1;
    cathode_d = SEG_BLANK;
    if (en && (slot_cnt_q >= CNT_GHOST)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_d[i] = (digit_idx_q != i[IDX_W-1:0]);
      end
      cathode_d = dec_cathode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
      anode_q      <= '1;
      cathode_q    <= SEG_BLANK;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_driver: directed + random stimulus against a frame model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int fd_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SC),
    .GHOST_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .bcd        (bcd),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .anode      (anode),
    .cathode    (cathode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // Reference: scan position as a count of enabled cycles, plus frame contents.
  int unsigned m_scan;
  logic [15:0] m_act_bcd, m_pend_bcd;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_act_blz, m_pend_blz, m_pend_valid;
  logic [3:0]  exp_anode;
  logic [7:0]  exp_cathode;
  logic [1:0]  exp_idx;
  logic [7:0]  glyph_tab [16];

  function automatic logic [7:0] ref_cathode(input int d);
    logic [7:0] c;
    logic [3:0] v;
    v = m_act_bcd[4*d +: 4];
    if (m_act_blz && d > 0 && (m_act_bcd >> (4*d)) == 16'd0) c = 8'hFF;
    else                                                     c = glyph_tab[v];
    if (m_act_dp[d]) c = c & 8'hFE;
    return c;
  endfunction

  task automatic model_reset();
    m_scan       = 0;
    m_act_bcd    = '0; m_pend_bcd = '0;
    m_act_dp     = '0; m_pend_dp  = '0;
    m_act_blz    = 1'b0; m_pend_blz = 1'b0;
    m_pend_valid = 1'b0;
    exp_anode    = 4'hF;
    exp_cathode  = 8'hFF;
    exp_idx      = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check registered outputs, drive inputs, predict the next edge.
  task automatic step(input logic e, input logic l, input logic [15:0] b,
                      input logic [3:0] d, input logic z);
    bit boundary;
    int slot;
    @(negedge clk);
    chk("anode", {28'd0, anode}, {28'd0, exp_anode});
    chk("cathode", {24'd0, cathode}, {24'd0, exp_cathode});
    chk("digit_idx", {30'd0, digit_idx}, {30'd0, exp_idx});
    en = e; load = l; bcd = b; dp_en = d; blank_lz = z;
    #1;
    boundary = e && ((m_scan % (SC*ND)) == SC*ND - 1);
    chk("frame_done", {31'd0, frame_done}, {31'd0, boundary});
    if (frame_done === 1'b1) fd_count++;
    slot = int'((m_scan / SC) % ND);
    if (e && (m_scan % SC) >= GC) begin
      exp_anode   = ~(4'b0001 << slot);
      exp_cathode = ref_cathode(slot);
    end else begin
      exp_anode   = 4'hF;
      exp_cathode = 8'hFF;
    end
    if (boundary && m_pend_valid) begin
      m_act_bcd = m_pend_bcd; m_act_dp = m_pend_dp; m_act_blz = m_pend_blz;
      m_pend_valid = 1'b0;
    end
    if (l) begin
      m_pend_bcd = b; m_pend_dp = d; m_pend_blz = z; m_pend_valid = 1'b1;
    end
    if (e) m_scan++;
    exp_idx = 2'((m_scan / SC) % ND);
  endtask

  task automatic idle(input int n, input logic e);
    for (int k = 0; k < n; k++) step(e, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  // At most one digit may be selected at any time.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      assert ($countones(~anode) <= 1) else begin
        errors++;
        $error("FAIL anode_onehot observed=%b expected=at most one low bit", anode);
      end
    end
  end

  initial begin
    glyph_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                  8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
    reset = 1'b1; en = 1'b0; load = 1'b0; bcd = '0; dp_en = '0; blank_lz = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    en = 1'b1;
    #1;
    chk("rst_anode", {28'd0, anode}, 32'hF);
    chk("rst_cathode", {24'd0, cathode}, 32'hFF);
    chk("rst_idx", {30'd0, digit_idx}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;

    // Basic digits
    step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    idle(70, 1'b1);

    // Leading-zero blanking, including an all-zero word
    step(1'b1, 1'b1, 16'h0040, 4'h0, 1'b1);
    idle(70, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(70, 1'b1);

    // Two loads within one frame: last wins, no tearing; frame_done rate
    idle(10, 1'b1);
    step(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    fd_start = fd_count;
    idle(64, 1'b1);
    chk("frame_done_rate", fd_count - fd_start, 32'd2);
    idle(10, 1'b1);

    // Error glyph with decimal point, dp over a blanked-zero region
    step(1'b1, 1'b1, 16'h0AB5, 4'b0100, 1'b0);
    idle(70, 1'b1);
    step(1'b1, 1'b1, 16'h0005, 4'b1000, 1'b1);
    idle(70, 1'b1);

    // Pause mid-slot, load while paused, then resume
    idle(3, 1'b1);
    idle(5, 1'b0);
    step(1'b0, 1'b1, 16'h9876, 4'b0001, 1'b0);
    idle(60, 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 10) != 0, ($urandom % 16) == 0,
           16'($urandom), 4'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-slot
    idle(13, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_anode", {28'd0, anode}, 32'hF);
    chk("async_cathode", {24'd0, cathode}, 32'hFF);
    chk("async_idx", {30'd0, digit_idx}, 32'd0);
    chk("async_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    reset = 1'b0;
    model_reset();
    idle(40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
